// File: rtl/pipe_credit_pkg.sv
// pipe_credit_pkg
// Shared sizing helpers and statistics types for the pipe_credit_ctrl slice.
//   cnt_w(depth) : width of a counter that must hold 0..depth
//   stat_t       : statistics counter type (32 bits)
//   STAT_MAX     : saturation value of stat_t
//   sat_inc(v)   : saturating increment of a stat_t
package pipe_credit_pkg;

   localparam int STAT_W = 32;

   typedef logic [STAT_W-1:0] stat_t;

   localparam stat_t STAT_MAX = '1;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic stat_t sat_inc(input stat_t v);
      return (v == STAT_MAX) ? v : v + stat_t'(1);
   endfunction

endpackage

// File: rtl/pipe_credit_fifo.sv
// pipe_credit_fifo
// DEPTH x DW circular result buffer with first-word fall-through head.
// Pointers wrap modulo DEPTH, so DEPTH does not have to be a power of two.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pointers/count clear)
//   push        : write push_data at the tail this cycle
//   push_data   : data to store
//   pop         : advance the head (ignored while empty)
//   valid       : buffer non-empty (registered)
//   head_data   : oldest entry; meaningless while valid=0
//   count       : number of stored entries
module pipe_credit_fifo
   import pipe_credit_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [DW-1:0]           push_data,
   input  logic                    pop,
   output logic                    valid,
   output logic [DW-1:0]           head_data,
   output logic [cnt_w(DEPTH)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop_ok    = pop && (cnt != '0);
   assign valid     = (cnt != '0);
   assign head_data = mem[head];
   assign count     = cnt;

   always_comb begin
      cnt_nxt = cnt;
      if (push && !pop_ok) begin
         cnt_nxt = cnt + CW'(1);
      end else if (!push && pop_ok) begin
         cnt_nxt = cnt - CW'(1);
      end
   end

   // Storage carries no reset; only the bookkeeping does.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            tail <= ptr_inc(tail);
         end
         if (pop_ok) begin
            head <= ptr_inc(head);
         end
         cnt <= cnt_nxt;
      end
   end

   // Credits guarantee a free slot for every returning result; a push into
   // a full buffer without a simultaneous pop means the credit logic broke.
   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop_ok && (cnt == CW'(DEPTH))));

endmodule

// File: rtl/pipe_credit_ctrl.sv
// pipe_credit_ctrl
// Credit-based flow controller for a fixed-latency, non-stallable datapath.
// A request is issued only when a result slot is reserved; the result comes
// back LAT cycles later, is captured into the output buffer, and leaves
// downstream in issue order.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1
// at the rising clock edge. in_ready never depends on in_valid; out_valid
// never depends on out_ready; a holder of valid keeps its data stable until
// the transfer.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : upstream request valid
//   in_ready     : a credit is available (0 while rst=1)
//   in_data      : request payload
//   dp_en        : issue strobe into the datapath (in_valid & in_ready)
//   dp_data      : request payload forwarded to the datapath
//   dp_res       : datapath result, sampled LAT cycles after issue
//   out_valid    : result buffer non-empty
//   out_ready    : downstream accept
//   out_data     : oldest buffered result
// Optional build macro PIPE_CREDIT_STATS_EN adds:
//   stat_issued  : saturating count of issues
//   stat_stall   : saturating count of cycles with in_valid & ~in_ready
//   stat_maxocc  : peak of (in flight + buffered)
module pipe_credit_ctrl
   import pipe_credit_pkg::*;
#(
   parameter int DW_I  = 16,
   parameter int DW_O  = 16,
   parameter int LAT   = 4,
   parameter int DEPTH = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DW_I-1:0]         in_data,
   output logic                    dp_en,
   output logic [DW_I-1:0]         dp_data,
   input  logic [DW_O-1:0]         dp_res,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DW_O-1:0]         out_data
`ifdef PIPE_CREDIT_STATS_EN
   ,
   output stat_t                   stat_issued,
   output stat_t                   stat_stall,
   output logic [cnt_w(DEPTH)-1:0] stat_maxocc
`endif
);

   localparam int CW = cnt_w(DEPTH);

   // Bit i set means an operation issued i+1 cycles ago is in the datapath;
   // the top bit lines up with its result appearing on dp_res.
   logic [LAT-1:0] trk;
   logic [LAT-1:0] trk_nxt;
   logic           rsp_vld;

   logic [CW-1:0]  credits;
   logic [CW-1:0]  credits_nxt;
   logic [CW-1:0]  buf_count;
   logic           pop;

   // Gated by rst so upstream sees no credit during reset, even before the
   // counter has been loaded.
   assign in_ready = !rst && (credits != '0);
   assign dp_en    = in_valid && in_ready;
   assign dp_data  = in_data;
   assign rsp_vld  = trk[LAT-1];
   assign pop      = out_valid && out_ready;

   always_comb begin
      trk_nxt    = trk << 1;
      trk_nxt[0] = dp_en;
   end

   // A credit returned by a pop is usable from the next cycle only.
   always_comb begin
      credits_nxt = credits;
      if (dp_en && !pop) begin
         credits_nxt = credits - CW'(1);
      end else if (!dp_en && pop) begin
         credits_nxt = credits + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trk     <= '0;
         credits <= CW'(DEPTH);
      end else begin
         trk     <= trk_nxt;
         credits <= credits_nxt;
      end
   end

   pipe_credit_fifo #(
      .DW    (DW_O),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rsp_vld),
      .push_data (dp_res),
      .pop       (pop),
      .valid     (out_valid),
      .head_data (out_data),
      .count     (buf_count)
   );

   // Every slot is either a free credit, an operation in flight, or a
   // buffered result.
   credit_invariant: assert property (@(posedge clk) disable iff (rst)
      (int'(credits) + $countones(trk) + int'(buf_count)) == DEPTH);

`ifdef PIPE_CREDIT_STATS_EN
   logic [CW-1:0] occ;

   assign occ = CW'(DEPTH) - credits;

   // stat_maxocc is bounded by DEPTH, so it cannot overflow its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
         stat_maxocc <= '0;
      end else begin
         if (dp_en) begin
            stat_issued <= sat_inc(stat_issued);
         end
         if (in_valid && !in_ready) begin
            stat_stall <= sat_inc(stat_stall);
         end
         if (occ > stat_maxocc) begin
            stat_maxocc <= occ;
         end
      end
   end
`endif

endmodule
